// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for one port of the shared memory arbiter.
// The requester drives the master modport; the arbiter takes the slave modport.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory port: fixed priority to m0,
// with m1 forced through after MAX_WAIT consecutive m0 wins it had to watch.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     m0,
    mem_port_arbiter_if.slave     m1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  busy,
    output logic                  owner
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAT_INIT   = CW'(MEM_LAT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [SW-1:0]   starve_cnt_r;
    logic            we_r;
    logic [AW-1:0]   addr_r;
    logic [DW-1:0]   wdata_r;
    logic            owner_r;
    logic            mem_en_r;
    logic            busy_r;
    logic            ready0_r;
    logic            ready1_r;
    logic [DW-1:0]   rdata0_r;
    logic [DW-1:0]   rdata1_r;

    logic            grant_any_s;
    logic            grant_m1_s;
    logic [SW-1:0]   starve_nxt_s;
    logic            sel_we_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wdata_s;

    // Winner selection and starvation counter update for the IDLE grant decision.
    always_comb begin
        grant_any_s  = m0.req | m1.req;
        grant_m1_s   = 1'b0;
        starve_nxt_s = starve_cnt_r;
        if (m1.req && (!m0.req || (starve_cnt_r == STARVE_MAX))) begin
            grant_m1_s = 1'b1;
        end else begin
            grant_m1_s = 1'b0;
        end
        if (grant_m1_s) begin
            starve_nxt_s = '0;
        end else if (m0.req && m1.req && (starve_cnt_r != STARVE_MAX)) begin
            starve_nxt_s = starve_cnt_r + 1'b1;
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
        if (grant_m1_s) begin
            sel_we_s    = m1.we;
            sel_addr_s  = m1.addr;
            sel_wdata_s = m1.wdata;
        end else begin
            sel_we_s    = m0.we;
            sel_addr_s  = m0.addr;
            sel_wdata_s = m0.wdata;
        end
    end

    // Access sequencer: IDLE -> ISSUE -> WAIT (reads) -> RESP, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            starve_cnt_r <= '0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            owner_r      <= 1'b0;
            mem_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            ready0_r     <= 1'b0;
            ready1_r     <= 1'b0;
            rdata0_r     <= '0;
            rdata1_r     <= '0;
        end else begin
            mem_en_r <= 1'b0;
            ready0_r <= 1'b0;
            ready1_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        state_r      <= ST_ISSUE;
                        we_r         <= sel_we_s;
                        addr_r       <= sel_addr_s;
                        wdata_r      <= sel_wdata_s;
                        owner_r      <= grant_m1_s;
                        starve_cnt_r <= starve_nxt_s;
                        mem_en_r     <= 1'b1;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (we_r) begin
                        state_r  <= ST_RESP;
                        ready0_r <= ~owner_r;
                        ready1_r <= owner_r;
                    end else begin
                        state_r <= ST_WAIT;
                        cnt_r   <= LAT_INIT;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 1'b1;
                    // cnt==1 is the cycle the memory presents data for this access
                    if (cnt_r == CW'(1)) begin
                        state_r  <= ST_RESP;
                        ready0_r <= ~owner_r;
                        ready1_r <= owner_r;
                        if (owner_r) begin
                            rdata1_r <= mem_rdata;
                        end else begin
                            rdata0_r <= mem_rdata;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign busy      = busy_r;
    assign owner     = owner_r;
    assign m0.ready  = ready0_r;
    assign m1.ready  = ready1_r;
    assign m0.rdata  = rdata0_r;
    assign m1.rdata  = rdata1_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences, and a randomized run against a cycle-count transaction model.
module tb_mem_port_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MEM_LAT  = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    // Memory with MEM_LAT read latency; junk on non-read cycles exposes mistimed captures.
    logic [31:0] mem_arr [0:127] = '{4: 32'hE3A0_0005, default: 32'h0};
    logic [31:0] rd_pipe [0:MEM_LAT-1] = '{default: 32'h0};

    always @(posedge clk) begin
        if (mem_en && mem_we) mem_arr[mem_addr[8:2]] <= mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[8:2]] : (32'hA5A5_0000 ^ 32'(cyc));
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    typedef struct {
        bit          who;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit who, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (who) begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
        end else begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
        end
    endtask

    function automatic logic get_ready(input bit who);
        return who ? m1_if.ready : m0_if.ready;
    endfunction

    function automatic logic [31:0] get_rdata(input bit who);
        return who ? m1_if.rdata : m0_if.rdata;
    endfunction

    // One transaction from IDLE; checks issue cycle, latency, data and return to idle.
    task automatic run_vec(input int idx, input vec_t v);
        int n; bit got; int en_cnt; int en_at; bit other_rdy;
        n = 0; got = 1'b0; en_cnt = 0; en_at = -1; other_rdy = 1'b0;
        drive(v.who, 1'b1, v.we, v.addr, v.wdata);
        drive(!v.who, 1'b0, 1'b0, 32'h0, 32'h0);
        while (!got && n < 20) begin
            tick;
            n++;
            if (mem_en) begin
                en_cnt++;
                if (en_at < 0) begin
                    en_at = n;
                    check($sformatf("vec%0d mem_addr", idx), mem_addr, v.addr);
                    check($sformatf("vec%0d mem_we", idx), 32'(mem_we), 32'(v.we));
                    if (v.we) check($sformatf("vec%0d mem_wdata", idx), mem_wdata, v.wdata);
                end
            end
            if (get_ready(!v.who)) other_rdy = 1'b1;
            if (get_ready(v.who)) got = 1'b1;
        end
        check($sformatf("vec%0d latency", idx), got ? 32'(n) : 32'hFFFF_FFFF, 32'(v.exp_lat));
        check($sformatf("vec%0d issue cycle", idx), 32'(en_at), 32'd1);
        check($sformatf("vec%0d mem_en count", idx), 32'(en_cnt), 32'd1);
        check($sformatf("vec%0d other ready", idx), 32'(other_rdy), 32'd0);
        check($sformatf("vec%0d rdata", idx), get_rdata(v.who), v.exp_rdata);
        tick;
        drive(v.who, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        tick;
        check($sformatf("vec%0d idle after", idx), {30'd0, busy, mem_en}, 32'd0);
    endtask

    // Randomized traffic against a transaction model based on grant cycle and access length.
    task automatic run_random(input int ncyc);
        logic [31:0] model_mem [0:127];
        bit          has_g, g_owner, g_we, w, idle;
        int          g_cyc, g_len, fin, starve;
        logic [31:0] g_addr, g_wdata, g_data;
        logic [31:0] exp_rd [0:1];
        bit          pend [0:1];
        bit          a_req [0:1];
        bit          a_we [0:1];
        logic [31:0] a_addr [0:1];
        logic [31:0] a_wdata [0:1];
        for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;
        has_g = 1'b0; g_owner = 1'b0; g_we = 1'b0; g_cyc = 0; g_len = 0; starve = 0;
        g_addr = 32'h0; g_wdata = 32'h0; g_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            exp_rd[i] = 32'h0; pend[i] = 1'b0; a_req[i] = 1'b0; a_we[i] = 1'b0;
            a_addr[i] = 32'h0; a_wdata[i] = 32'h0;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            fin = g_cyc + g_len;
            if (has_g && k == fin && !g_we) exp_rd[g_owner] = g_data;
            check("rnd busy", 32'(busy), 32'(has_g && k > g_cyc && k <= fin));
            check("rnd mem_en", 32'(mem_en), 32'(has_g && k == g_cyc + 1));
            check("rnd m0_ready", 32'(m0_if.ready), 32'(has_g && k == fin && !g_owner));
            check("rnd m1_ready", 32'(m1_if.ready), 32'(has_g && k == fin && g_owner));
            check("rnd owner", 32'(owner), 32'(g_owner));
            check("rnd mem_addr", mem_addr, g_addr);
            check("rnd mem_we", 32'(mem_we), 32'(g_we));
            check("rnd mem_wdata", mem_wdata, g_wdata);
            check("rnd m0_rdata", m0_if.rdata, exp_rd[0]);
            check("rnd m1_rdata", m1_if.rdata, exp_rd[1]);
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && k > fin) begin
                    pend[i] = 1'b0;
                    a_req[i] = 1'b0;
                end
                if (pend[i]) begin
                    if (k > g_cyc) begin
                        a_we[i] = 1'($urandom_range(0, 1));
                        a_addr[i] = $urandom;
                        a_wdata[i] = $urandom;
                    end
                end else if (a_req[i]) begin
                    if ($urandom_range(0, 7) == 0) a_req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    a_req[i] = 1'b1;
                    a_we[i] = 1'($urandom_range(0, 1));
                    a_addr[i] = 32'h100 + ($urandom_range(0, 63) << 2);
                    a_wdata[i] = $urandom;
                end
            end
            drive(1'b0, a_req[0], a_we[0], a_addr[0], a_wdata[0]);
            drive(1'b1, a_req[1], a_we[1], a_addr[1], a_wdata[1]);
            idle = !has_g || k > fin;
            if (idle && (a_req[0] || a_req[1])) begin
                w = a_req[1] && (!a_req[0] || starve == MAX_WAIT);
                if (w) starve = 0;
                else if (a_req[1] && starve < MAX_WAIT) starve++;
                has_g = 1'b1; g_cyc = k; g_owner = w; g_we = a_we[w];
                g_addr = a_addr[w]; g_wdata = a_wdata[w];
                g_len = g_we ? 2 : 2 + MEM_LAT;
                if (g_we) model_mem[g_addr[8:2]] = g_wdata;
                else g_data = model_mem[g_addr[8:2]];
                pend[w] = 1'b1;
            end
            tick;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (8) tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [0:6];
        int   gcnt, last, n, rc;
        bit   owners [0:9];
        bit   flag;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hE3A0_0005, 2 + MEM_LAT};
        vecs[1] = '{1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0,         2};
        vecs[2] = '{1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'hE3A0_0005, 2};
        vecs[3] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'h1234_5678, 2 + MEM_LAT};
        vecs[4] = '{1'b1, 1'b0, 32'h40, 32'h0,         32'hDEAD_BEEF, 2 + MEM_LAT};
        vecs[5] = '{1'b1, 1'b1, 32'h44, 32'h0BAD_F00D, 32'hDEAD_BEEF, 2};
        vecs[6] = '{1'b0, 1'b0, 32'h44, 32'h0,         32'h0BAD_F00D, 2 + MEM_LAT};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) tick;
        check("reset outs", {25'd0, busy, mem_en, mem_we, owner, m0_if.ready, m1_if.ready, 1'b0}, 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset m0_rdata", m0_if.rdata, 32'h0);
        check("reset m1_rdata", m1_if.rdata, 32'h0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset during the WAIT phase of an m0 read abandons it.
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        tick;
        tick;
        check("t4 busy in wait", 32'(busy), 32'd1);
        reset = 1'b1;
        tick;
        check("t4 busy", 32'(busy), 32'd0);
        check("t4 mem_en", 32'(mem_en), 32'd0);
        check("t4 m0_ready", 32'(m0_if.ready), 32'd0);
        check("t4 m0_rdata", m0_if.rdata, 32'h0);
        check("t4 owner", 32'(owner), 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        flag = 1'b0;
        repeat (6) begin
            tick;
            if (m0_if.ready || mem_en) flag = 1'b1;
        end
        check("t4 no late activity", 32'(flag), 32'd0);

        // Both requesting continuously: m1 forced through every MAX_WAIT+1 grants.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'h80, 32'h1111_0000);
        drive(1'b1, 1'b1, 1'b1, 32'h84, 32'h2222_0000);
        gcnt = 0; last = -1; n = 0;
        while (gcnt < 10 && n < 80) begin
            tick;
            n++;
            if (mem_en) begin
                owners[gcnt] = owner;
                if (last >= 0) check("t3 grant spacing", 32'(n - last), 32'd3);
                last = n;
                gcnt++;
            end
        end
        check("t3 grant count", 32'(gcnt), 32'd10);
        for (int i = 0; i < gcnt; i++)
            check($sformatf("t3 grant%0d owner", i), 32'(owners[i]), 32'((i % (MAX_WAIT + 1)) == MAX_WAIT));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (8) tick;
        check("t3 drained", 32'(busy), 32'd0);

        // m1 withdraws address and request right after grant; latched copy is used.
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        tick;
        check("t6 issue", 32'(mem_en), 32'd1);
        check("t6 issue addr", mem_addr, 32'h40);
        drive(1'b1, 1'b0, 1'b1, 32'h99C, 32'hFFFF_FFFF);
        rc = 0;
        flag = 1'b0;
        repeat (8) begin
            tick;
            if (m1_if.ready) begin
                rc++;
                check("t6 rdata", m1_if.rdata, 32'hDEAD_BEEF);
            end
            if (mem_en) flag = 1'b1;
        end
        check("t6 ready count", 32'(rc), 32'd1);
        check("t6 no reissue", 32'(flag), 32'd0);
        check("t6 held addr", mem_addr, 32'h40);
        check("t6 held we", 32'(mem_we), 32'd0);

        run_random(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
